dice_roller: RTL
================

Name: dice_roller

Overview:
Upstream stage of the dice face decoder. Turns a raw push-button into a "rolling dice" face value.
- While the button is held, the face spins at a fixed rate.
- On release, the face spin decelerates over a fixed number of steps, then settles.
- Output value[2:0] drives the 3-bit face select consumed by the decoder and segment-to-pin multiplexer.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synchronized cycles required to accept a button level change (>=2)
ROLL_TICK, 1000000, clk cycles between face advances while held (>=2)
SLOWDOWN_STEPS, 6, face advances during deceleration after release (1..8)
FACES, 6, number of faces; value range 0..FACES-1 (2..8)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn  input  1  raw push-button, asynchronous to clk, active-high
value  output  3  current face, 0..FACES-1
rolling  output  1  high in ROLL or SLOW states
valid  output  1  high once a roll has settled; cleared when a new roll starts

Behaviour:
- Clock and reset are fixed: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release through the normal flop path):
  - value=0, rolling=0, valid=0, state=IDLE
  - sync flops=0, debounced level=0, all counters=0
- Synchronizer: btn passes through a 2-flop synchronizer to give btn_s.
- Debounce:
  - Counter clears whenever btn_s equals the debounced level btn_db.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, btn_db toggles and the counter clears.
  - Net latency from btn edge to btn_db edge is 2+DEBOUNCE_CYCLES cycles, for a clean edge.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Edge detect: rise/fall are single-cycle pulses derived from btn_db versus its registered copy.
- Tick counter tcnt:
  - Width is $clog2(ROLL_TICK<<SLOWDOWN_STEPS)+1.
  - Compared against the current interval ivl.
  - When tcnt==ivl-1, an advance occurs and tcnt clears.
- States:
  - IDLE:
    - rolling=0; value held.
    - On rise: go to ROLL, tcnt=0, ivl=ROLL_TICK, valid<=0.
  - ROLL:
    - rolling=1; an advance every ROLL_TICK cycles.
    - On fall: go to SLOW, step=0, ivl=ROLL_TICK<<1, tcnt=0.
    - A fall on the same cycle as an advance: the advance is applied, then the state goes to SLOW.
  - SLOW:
    - rolling=1.
    - On each advance: step++ and ivl<<=1.
    - When the advance makes step==SLOWDOWN_STEPS: go to IDLE, valid<=1.
    - On rise: back to ROLL, ivl=ROLL_TICK, tcnt=0, step=0. This has priority over a coincident advance (the advance is dropped).
- Advance rule: value <= (value==FACES-1) ? 0 : value+1. Compare-and-wrap only; no modulo operator.
- value, rolling and valid are all registered outputs, with no combinational path from btn.
- The SLOW phase lasts exactly ROLL_TICK*(2+4+...+2^SLOWDOWN_STEPS) cycles.

Optional Feature:
Macro: DICE_ROLLER_LFSR_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) shifts every clk cycle, including in IDLE.
  - Each advance adds 1+lfsr[1:0] to value, wrapping modulo FACES by repeated conditional subtract of FACES (at most 2 subtracts for the allowed range).
  - Result: settled face depends on press timing as well as press duration.
- Undefined:
  - No LFSR logic; advance is +1 with wrap, as above.
  - Output is deterministic for a given press duration.

Decomposition:
- Package dice_pkg:
  - typedef enum logic [1:0] {IDLE, ROLL, SLOW} roll_state_t
  - localparam MAX_FACES=8
  - localparam LFSR_SEED=16'hACE1
  - localparam LFSR_TAPS=16'hB400
  - function next_face(value, inc, faces)
- Sub-module button_debouncer:
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, rst_n, btn -> btn_db, rise, fall.
  - Contains the 2-flop synchronizer, the debounce counter and the edge detect.
  - Reusable for future select buttons.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, ROLL_TICK=8, SLOWDOWN_STEPS=3, FACES=6, macro undefined.
1. Reset: rst_n low 3 cycles, then high -> value=0, rolling=0, valid=0; stable for 50 cycles with btn=0.
2. Glitch: btn high 3 cycles, then low -> no rise; state stays IDLE; rolling stays 0.
3. Hold: btn high 100 cycles -> rolling=1 from debounce latency+1; value steps 0,1,2,3,4,5,0,... once every 8 cycles; valid=0.
4. Release after 6 ROLL advances (value=0) -> further advances after 16, 32 and 64 cycles (value 1,2,3); then rolling=0, valid=1, value=3 held for 200 cycles.
5. Re-press during SLOW (after the first slow advance) -> back to ROLL; next advance exactly 8 cycles after rise; valid stays 0.
6. Assert rst_n mid-ROLL (value=4) -> value=0, rolling=0, valid=0 immediately without a clk edge; with btn still high after release, the block re-rolls only after a full debounce of a new rise.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice roller: FSM state encoding, LFSR constants
// and the face-advance wrap function.
package dice_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ROLL = 2'd1,
      SLOW = 2'd2
   } roll_state_t;

   localparam int          MAX_FACES = 8;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // inc is at most 4, so two conditional subtracts always land back in 0..faces-1
   function automatic logic [2:0] next_face(input logic [2:0] value,
                                            input logic [2:0] inc,
                                            input logic [3:0] faces);
      logic [3:0] sum;
      sum = {1'b0, value} + {1'b0, inc};
      if (sum >= faces) begin
         sum = sum - faces;
      end
      if (sum >= faces) begin
         sum = sum - faces;
      end
      return sum[2:0];
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stable-level debounce counter and single-cycle edge pulses
// for a raw push-button.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic btn_db,
   output logic rise,
   output logic fall
);

   localparam int            CW     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_L = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          btn_s_r;
   logic          btn_db_r;
   logic          db_dly_r;
   logic [CW-1:0] cnt_r;

   // Synchronize, count consecutive disagreeing cycles, toggle the accepted level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r  <= 1'b0;
         btn_s_r  <= 1'b0;
         btn_db_r <= 1'b0;
         db_dly_r <= 1'b0;
         cnt_r    <= '0;
      end else begin
         sync1_r  <= btn;
         btn_s_r  <= sync1_r;
         db_dly_r <= btn_db_r;
         if (btn_s_r == btn_db_r) begin
            cnt_r <= '0;
         end else if (cnt_r == LAST_L) begin
            btn_db_r <= ~btn_db_r;
            cnt_r    <= '0;
         end else begin
            cnt_r <= cnt_r + CW'(1'b1);
         end
      end
   end

   assign btn_db = btn_db_r;
   assign rise   = btn_db_r & ~db_dly_r;
   assign fall   = ~btn_db_r & db_dly_r;

endmodule

// File: rtl/dice_roller.sv
// Rolling-dice face generator: spins while the button is held, decelerates after release.
// Optional macro DICE_ROLLER_LFSR_EN adds a pseudo-random 1..4 step per advance.
module dice_roller
   import dice_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int ROLL_TICK       = 1000000,
   parameter int SLOWDOWN_STEPS  = 6,
   parameter int FACES           = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   output logic [2:0] value,
   output logic       rolling,
   output logic       valid
);

   localparam int            TW      = $clog2(ROLL_TICK << SLOWDOWN_STEPS) + 1;
   localparam logic [TW-1:0] TICK_L  = TW'(ROLL_TICK);
   localparam logic [TW-1:0] TICK2_L = TW'(ROLL_TICK * 2);
   localparam logic [3:0]    STEPS_L = 4'(SLOWDOWN_STEPS);
   localparam logic [3:0]    FACES_L = 4'(FACES);

   logic          btn_db_s, rise_s, fall_s;
   roll_state_t   state_r, state_nxt_s;
   logic [TW-1:0] tcnt_r, tcnt_nxt_s, ivl_r, ivl_nxt_s;
   logic [3:0]    step_r, step_nxt_s, step_inc_s;
   logic [2:0]    value_r, value_nxt_s, face_s, inc_s;
   logic          valid_r, valid_nxt_s, rolling_r, adv_s;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn    (btn),
      .btn_db (btn_db_s),
      .rise   (rise_s),
      .fall   (fall_s)
   );

`ifdef DICE_ROLLER_LFSR_EN
   logic [15:0] lfsr_r;

   // Free-running Fibonacci LFSR so the settled face depends on press timing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r <= LFSR_SEED;
      end else begin
         lfsr_r <= {lfsr_r[14:0], ^(lfsr_r & LFSR_TAPS)};
      end
   end

   assign inc_s = 3'd1 + {1'b0, lfsr_r[1:0]};
`else
   assign inc_s = 3'd1;
`endif

   assign adv_s      = (tcnt_r == (ivl_r - TW'(1'b1)));
   assign step_inc_s = step_r + 4'd1;
   assign face_s     = next_face(value_r, inc_s, FACES_L);

   // Next-state and datapath decisions for the roll/slowdown sequence
   always_comb begin
      state_nxt_s = state_r;
      tcnt_nxt_s  = tcnt_r;
      ivl_nxt_s   = ivl_r;
      step_nxt_s  = step_r;
      value_nxt_s = value_r;
      valid_nxt_s = valid_r;
      case (state_r)
         IDLE: begin
            tcnt_nxt_s = '0;
            if (rise_s && btn_db_s) begin
               state_nxt_s = ROLL;
               ivl_nxt_s   = TICK_L;
               step_nxt_s  = 4'd0;
               valid_nxt_s = 1'b0;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ROLL: begin
            if (adv_s) begin
               value_nxt_s = face_s;
               tcnt_nxt_s  = '0;
            end else begin
               tcnt_nxt_s = tcnt_r + TW'(1'b1);
            end
            // a coincident advance is kept; only the interval restarts
            if (fall_s) begin
               state_nxt_s = SLOW;
               step_nxt_s  = 4'd0;
               ivl_nxt_s   = TICK2_L;
               tcnt_nxt_s  = '0;
            end else begin
               state_nxt_s = ROLL;
            end
         end
         SLOW: begin
            if (rise_s) begin
               state_nxt_s = ROLL;
               ivl_nxt_s   = TICK_L;
               tcnt_nxt_s  = '0;
               step_nxt_s  = 4'd0;
            end else if (adv_s) begin
               value_nxt_s = face_s;
               tcnt_nxt_s  = '0;
               step_nxt_s  = step_inc_s;
               ivl_nxt_s   = {ivl_r[TW-2:0], 1'b0};
               if (step_inc_s == STEPS_L) begin
                  state_nxt_s = IDLE;
                  valid_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = SLOW;
               end
            end else begin
               tcnt_nxt_s = tcnt_r + TW'(1'b1);
            end
         end
         default: begin
            state_nxt_s = IDLE;
            tcnt_nxt_s  = '0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         tcnt_r    <= '0;
         ivl_r     <= '0;
         step_r    <= 4'd0;
         value_r   <= 3'd0;
         valid_r   <= 1'b0;
         rolling_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         tcnt_r    <= tcnt_nxt_s;
         ivl_r     <= ivl_nxt_s;
         step_r    <= step_nxt_s;
         value_r   <= value_nxt_s;
         valid_r   <= valid_nxt_s;
         rolling_r <= (state_nxt_s != IDLE);
      end
   end

   assign value   = value_r;
   assign rolling = rolling_r;
   assign valid   = valid_r;

endmodule
